// File: rtl/cr_tlvp_term_relay.sv
// Terminate-to-user TLV relay: pops the parser's show-ahead terminate FIFO, checks
// declared vs observed TLV length, drops one programmable type, forwards the rest.
module cr_tlvp_term_relay #(
  parameter int DATA_W = 64,
  parameter int LEN_W  = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              term_empty,
  output logic              term_rd,
  input  logic [DATA_W-1:0] term_data,
  input  logic              term_sot,
  input  logic              term_eot,
  input  logic              usr_afull,
  output logic              usr_wr,
  output logic [DATA_W-1:0] usr_data,
  output logic              usr_sot,
  output logic              usr_eot,
  input  logic              drop_en,
  input  logic [7:0]        drop_type,
  output logic              len_err,
  output logic              proto_err,
  output logic [CNT_W-1:0]  tlv_pass_cnt,
  output logic [CNT_W-1:0]  tlv_drop_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  state_t           state, state_n;
  logic [LEN_W-1:0] wcnt, wcnt_n;
  logic [LEN_W-1:0] decl_len, decl_len_n;
  logic             fwd, len_err_n, proto_err_n;
  logic             pass_inc;
  logic [1:0]       drop_inc, err_inc;
  logic             sot_drop;
  logic [LEN_W-1:0] hdr_len, wcnt_inc;

  assign hdr_len  = term_data[8 +: LEN_W];
  assign sot_drop = term_sot && drop_en && (term_data[7:0] == drop_type);
  // A sot that will be dropped never reaches the user FIFO, so it may bypass afull.
  assign term_rd  = !term_empty && (state == DROP || sot_drop || !usr_afull);
  assign wcnt_inc = (wcnt == '1) ? wcnt : wcnt + 1'b1;
  assign err_inc  = {1'b0, len_err_n} + {1'b0, proto_err_n};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_n     = state;
    wcnt_n      = wcnt;
    decl_len_n  = decl_len;
    fwd         = 1'b0;
    len_err_n   = 1'b0;
    proto_err_n = 1'b0;
    pass_inc    = 1'b0;
    drop_inc    = 2'd0;
    if (term_rd) begin
      if (term_sot) begin
        // A sot inside an open TLV force-closes it without a length check.
        if (state != IDLE) proto_err_n = 1'b1;
        if (state == DROP) drop_inc = 2'd1;
        wcnt_n     = {{(LEN_W-1){1'b0}}, 1'b1};
        decl_len_n = hdr_len;
        if (sot_drop) begin
          state_n = DROP;
        end else begin
          state_n = PASS;
          fwd     = 1'b1;
        end
        if (term_eot) begin
          state_n   = IDLE;
          len_err_n = (hdr_len != {{(LEN_W-1){1'b0}}, 1'b1});
          if (sot_drop) drop_inc = drop_inc + 2'd1;
          else          pass_inc = 1'b1;
        end
      end else if (state == IDLE) begin
        proto_err_n = 1'b1;
      end else begin
        wcnt_n = wcnt_inc;
        fwd    = (state == PASS);
        if (term_eot) begin
          state_n   = IDLE;
          len_err_n = (wcnt_inc != decl_len);
          if (state == PASS) pass_inc = 1'b1;
          else               drop_inc = 2'd1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking here would race.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wcnt         <= '0;
      decl_len     <= '0;
      usr_wr       <= 1'b0;
      usr_data     <= '0;
      usr_sot      <= 1'b0;
      usr_eot      <= 1'b0;
      len_err      <= 1'b0;
      proto_err    <= 1'b0;
      tlv_pass_cnt <= '0;
      tlv_drop_cnt <= '0;
      err_cnt      <= '0;
    end else begin
      state        <= state_n;
      wcnt         <= wcnt_n;
      decl_len     <= decl_len_n;
      usr_wr       <= fwd;
      usr_sot      <= fwd && term_sot;
      usr_eot      <= fwd && term_eot;
      if (fwd) usr_data <= term_data;
      len_err      <= len_err_n;
      proto_err    <= proto_err_n;
      tlv_pass_cnt <= tlv_pass_cnt + CNT_W'(pass_inc);
      tlv_drop_cnt <= tlv_drop_cnt + CNT_W'(drop_inc);
      err_cnt      <= err_cnt + CNT_W'(err_inc);
    end
  end

endmodule

// File: tb/tb_cr_tlvp_term_relay.sv
// Directed bench for cr_tlvp_term_relay: acts as the show-ahead terminate FIFO and
// logs every user-FIFO write and error pulse for per-scenario comparison.
module tb_cr_tlvp_term_relay;

  localparam int DATA_W = 64;
  localparam int LEN_W  = 16;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              term_empty = 1'b1;
  logic              term_rd;
  logic [DATA_W-1:0] term_data = '0;
  logic              term_sot = 1'b0;
  logic              term_eot = 1'b0;
  logic              usr_afull = 1'b0;
  logic              usr_wr;
  logic [DATA_W-1:0] usr_data;
  logic              usr_sot, usr_eot;
  logic              drop_en = 1'b0;
  logic [7:0]        drop_type = 8'h00;
  logic              len_err, proto_err;
  logic [CNT_W-1:0]  tlv_pass_cnt, tlv_drop_cnt, err_cnt;

  cr_tlvp_term_relay #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .term_empty(term_empty), .term_rd(term_rd), .term_data(term_data),
    .term_sot(term_sot), .term_eot(term_eot),
    .usr_afull(usr_afull), .usr_wr(usr_wr), .usr_data(usr_data),
    .usr_sot(usr_sot), .usr_eot(usr_eot),
    .drop_en(drop_en), .drop_type(drop_type),
    .len_err(len_err), .proto_err(proto_err),
    .tlv_pass_cnt(tlv_pass_cnt), .tlv_drop_cnt(tlv_drop_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              s;
    logic              e;
    int                c;
  } rec_t;

  rec_t outq[$];
  int   acc_q[$];
  int   cyc = 0;
  int   n_lerr = 0, n_perr = 0, n_stall = 0, n_viol = 0;
  logic prev_afull = 1'b0;
  logic bp_mode = 1'b0;
  int   n_cmp = 0, n_fail = 0;

  always @(posedge clk) begin
    cyc++;
    prev_afull = usr_afull;
  end

  // Outputs are flops, so the falling edge sees the values launched by the last rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (usr_wr) begin
        rec_t r;
        r.d = usr_data; r.s = usr_sot; r.e = usr_eot; r.c = cyc;
        outq.push_back(r);
        if (bp_mode && prev_afull) n_viol++;
      end
      if (len_err)   n_lerr++;
      if (proto_err) n_perr++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    term_empty = 1'b1; term_sot = 1'b0; term_eot = 1'b0; usr_afull = 1'b0;
    outq.delete(); acc_q.delete();
    n_lerr = 0; n_perr = 0; n_stall = 0; n_viol = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Presents one word and holds it until the relay pops it; called at a falling edge.
  task automatic push(input logic [DATA_W-1:0] d, input logic s, input logic e);
    logic acc = 1'b0;
    int   waits = 0;
    term_data = d; term_sot = s; term_eot = e; term_empty = 1'b0;
    while (!acc) begin
      if (bp_mode) usr_afull = ($urandom_range(0, 3) == 0);
      #1;
      acc = term_rd;
      if (acc) acc_q.push_back(cyc);
      @(negedge clk);
      if (!acc) begin
        waits++;
        n_stall++;
        if (waits > 200) begin
          n_cmp++; n_fail++;
          $display("FAIL push_timeout: word %0h not popped after %0d cycles", d, waits);
          return;
        end
      end
    end
  endtask

  task automatic go_idle(input int n);
    term_empty = 1'b1; term_sot = 1'b0; term_eot = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    chk("rst_usr_wr", usr_wr, 0);
    chk("rst_usr_sot", usr_sot, 0);
    chk("rst_usr_eot", usr_eot, 0);
    chk("rst_usr_data", usr_data, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_pass_cnt", tlv_pass_cnt, 0);
    chk("rst_drop_cnt", tlv_drop_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_term_rd_empty", term_rd, 0);
  endtask

  task automatic test_pass3();
    do_reset();
    drop_en = 1'b0;
    push(64'h0305, 1'b1, 1'b0);
    push(64'hA1, 1'b0, 1'b0);
    push(64'hA2, 1'b0, 1'b1);
    go_idle(3);
    chk("pass3_nwr", outq.size(), 3);
    if (outq.size() == 3) begin
      chk("pass3_w0_data", outq[0].d, 64'h0305);
      chk("pass3_w0_sot", outq[0].s, 1);
      chk("pass3_w0_eot", outq[0].e, 0);
      chk("pass3_w1_data", outq[1].d, 64'hA1);
      chk("pass3_w1_flags", {outq[1].s, outq[1].e}, 2'b00);
      chk("pass3_w2_data", outq[2].d, 64'hA2);
      chk("pass3_w2_flags", {outq[2].s, outq[2].e}, 2'b01);
      chk("pass3_latency", outq[0].c, acc_q[0] + 1);
      chk("pass3_consec", outq[2].c - outq[0].c, 2);
    end
    chk("pass3_pass_cnt", tlv_pass_cnt, 1);
    chk("pass3_err_pulses", n_lerr + n_perr, 0);
    chk("pass3_err_cnt", err_cnt, 0);
  endtask

  task automatic test_drop();
    do_reset();
    drop_en = 1'b1; drop_type = 8'h05;
    usr_afull = 1'b1;
    push(64'h0405, 1'b1, 1'b0);
    push(64'hC1, 1'b0, 1'b0);
    push(64'hC2, 1'b0, 1'b0);
    push(64'hC3, 1'b0, 1'b1);
    usr_afull = 1'b0;
    push(64'h0206, 1'b1, 1'b0);
    push(64'hB1, 1'b0, 1'b1);
    go_idle(3);
    chk("drop_no_stall", n_stall, 0);
    chk("drop_rd_consec", acc_q[5] - acc_q[0], 5);
    chk("drop_nwr", outq.size(), 2);
    if (outq.size() == 2) begin
      chk("drop_w0", {outq[0].s, outq[0].e, outq[0].d}, {2'b10, 64'h0206});
      chk("drop_w1", {outq[1].s, outq[1].e, outq[1].d}, {2'b01, 64'hB1});
    end
    chk("drop_drop_cnt", tlv_drop_cnt, 1);
    chk("drop_pass_cnt", tlv_pass_cnt, 1);
    chk("drop_err_cnt", err_cnt, 0);
    drop_en = 1'b0;
  endtask

  task automatic test_len_err();
    do_reset();
    push(64'h0407, 1'b1, 1'b0);
    push(64'hD1, 1'b0, 1'b1);
    go_idle(3);
    chk("len_nwr", outq.size(), 2);
    chk("len_lerr_pulses", n_lerr, 1);
    chk("len_err_cnt", err_cnt, 1);
    chk("len_pass_cnt", tlv_pass_cnt, 1);
    push(64'h0008, 1'b1, 1'b1);
    go_idle(3);
    chk("len0_lerr_pulses", n_lerr, 2);
    chk("len0_err_cnt", err_cnt, 2);
    chk("len0_perr_pulses", n_perr, 0);
  endtask

  task automatic test_missing_eot();
    do_reset();
    push(64'h0309, 1'b1, 1'b0);
    push(64'hE1, 1'b0, 1'b0);
    push(64'h0109, 1'b1, 1'b1);
    go_idle(3);
    chk("meot_perr_pulses", n_perr, 1);
    chk("meot_lerr_pulses", n_lerr, 0);
    chk("meot_nwr", outq.size(), 3);
    if (outq.size() == 3) begin
      chk("meot_sot_flags", {outq[0].s, outq[1].s, outq[2].s}, 3'b101);
      chk("meot_eot_flags", {outq[0].e, outq[1].e, outq[2].e}, 3'b001);
      chk("meot_w2_data", outq[2].d, 64'h0109);
    end
    chk("meot_pass_cnt", tlv_pass_cnt, 1);
    chk("meot_err_cnt", err_cnt, 1);
    push(64'hEE, 1'b0, 1'b0);
    go_idle(3);
    chk("orphan_nwr", outq.size(), 3);
    chk("orphan_perr_pulses", n_perr, 2);
    chk("orphan_err_cnt", err_cnt, 2);
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] exp_d[$];
    logic [1:0]        exp_f[$];
    int                bad = 0;
    do_reset();
    bp_mode = 1'b1;
    for (int t = 0; t < 250; t++) begin
      for (int w = 0; w < 4; w++) begin
        logic [DATA_W-1:0] d;
        d = (w == 0) ? {32'(t), 16'h0000, 16'h0410} : {32'(t), 16'hF000, 16'(w)};
        exp_d.push_back(d);
        exp_f.push_back({w == 0, w == 3});
        push(d, w == 0, w == 3);
      end
    end
    bp_mode = 1'b0;
    usr_afull = 1'b0;
    go_idle(3);
    chk("bp_nwr", outq.size(), 1000);
    chk("bp_afull_violations", n_viol, 0);
    for (int i = 0; i < 1000 && i < outq.size(); i++)
      if (outq[i].d !== exp_d[i] || {outq[i].s, outq[i].e} !== exp_f[i]) bad++;
    chk("bp_stream_mismatches", bad, 0);
    chk("bp_pass_cnt", tlv_pass_cnt, 250);
    chk("bp_err_cnt", err_cnt, 0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(64'h0111, 1'b1, 1'b1);
    push(64'h0511, 1'b1, 1'b0);
    push(64'hF1, 1'b0, 1'b0);
    push(64'hF2, 1'b0, 1'b0);
    chk("rmid_pre_pass_cnt", tlv_pass_cnt, 1);
    rst_n = 1'b0;
    term_empty = 1'b1;
    #1;
    chk("rmid_usr_wr", usr_wr, 0);
    chk("rmid_usr_data", usr_data, 0);
    chk("rmid_pass_cnt", tlv_pass_cnt, 0);
    @(negedge clk);
    outq.delete(); n_lerr = 0; n_perr = 0;
    rst_n = 1'b1;
    @(negedge clk);
    push(64'h0212, 1'b1, 1'b0);
    push(64'hF3, 1'b0, 1'b1);
    go_idle(3);
    chk("rmid_nwr", outq.size(), 2);
    if (outq.size() == 2) chk("rmid_w0", {outq[0].s, outq[0].d}, {1'b1, 64'h0212});
    chk("rmid_perr_pulses", n_perr, 0);
    chk("rmid_lerr_pulses", n_lerr, 0);
    chk("rmid_post_pass_cnt", tlv_pass_cnt, 1);
  endtask

  initial begin
    test_reset();
    test_pass3();
    test_drop();
    test_len_err();
    test_missing_eot();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cr_tlvp_term_relay.md
# cr_tlvp_term_relay

User-side consumer of the TLV parser terminate interface. It pops TLV words from the parser's show-ahead terminate FIFO, checks each TLV's declared length against the observed word count, and drops TLVs of one programmable type. All other TLVs pass, registered, to the parser's user-insert FIFO under almost-full flow control. It closes the loop between the parser's `term_*` and `usr_*` ports when no user engine consumes them.

## Interface

Parameters:
- `DATA_W`, default 64: TLV data word width. Must be at least 32.
- `LEN_W`, default 16: width of the length field in the first TLV word, and of the word counter.
- `CNT_W`, default 32: width of the statistics counters.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset. Asynchronous, active-low.
- `term_empty`, in, 1: terminate FIFO empty.
- `term_rd`, out, 1: pop the terminate FIFO. The FIFO is show-ahead, so data is valid whenever `term_empty`=0.
- `term_data`, in, `DATA_W`: TLV word.
- `term_sot`, in, 1: first word of a TLV.
- `term_eot`, in, 1: last word of a TLV.
- `usr_afull`, in, 1: user FIFO almost full. It asserts with at least 2 free entries remaining.
- `usr_wr`, out, 1: push to the user FIFO.
- `usr_data`, out, `DATA_W`: forwarded word.
- `usr_sot`, out, 1: forwarded start-of-TLV flag.
- `usr_eot`, out, 1: forwarded end-of-TLV flag.
- `drop_en`, in, 1: enable type-based drop. Quasi-static.
- `drop_type`, in, 8: TLV type to drop. Quasi-static.
- `len_err`, out, 1: one-cycle pulse on a length mismatch.
- `proto_err`, out, 1: one-cycle pulse on a framing error.
- `tlv_pass_cnt`, out, `CNT_W`: count of TLVs forwarded.
- `tlv_drop_cnt`, out, `CNT_W`: count of TLVs dropped.
- `err_cnt`, out, `CNT_W`: count of length and protocol errors.

## Operation

- First-word fields:
  - type = `term_data[7:0]`.
  - declared length = `term_data[8+LEN_W-1:8]`, in words, header included.
  - A declared length of 0 is always a mismatch.
- States:
  - IDLE: no TLV open.
  - PASS: forwarding the open TLV.
  - DROP: discarding the open TLV.
- A word is accepted on any cycle where `term_rd`=1.
- `term_rd` = !`term_empty` && (state==DROP || the incoming word is a sot that will be dropped || !`usr_afull`). This is combinational from the inputs and the current state.
- Word accepted in IDLE with sot=1:
  - The word counter loads 1.
  - If `drop_en` && type==`drop_type`, the word is discarded. The state goes to DROP.
  - Otherwise the word is forwarded and the state goes to PASS.
  - If eot=1 on the same word (single-word TLV), the length check runs immediately and the state returns to IDLE.
- Word accepted in IDLE with sot=0:
  - The word is discarded.
  - `proto_err` pulses and `err_cnt` increments.
  - The state stays IDLE.
- Word accepted in PASS or DROP with sot=0:
  - The counter increments, saturating at all-ones.
  - PASS forwards the word; DROP discards it.
  - On eot, the final count is compared with the declared length. On a mismatch, `len_err` pulses and `err_cnt` increments. The state then goes to IDLE.
- Word accepted in PASS or DROP with sot=1 (missing eot):
  - `proto_err` pulses and `err_cnt` increments.
  - The open TLV is closed with no length check. No synthetic eot is emitted.
  - The word is then processed as a new sot from IDLE in the same cycle.
- `tlv_pass_cnt` increments on the eot of a forwarded TLV.
- `tlv_drop_cnt` increments on the eot of a dropped TLV, or on a forced close in DROP.
- All counters wrap silently.
- If `len_err` and `proto_err` fire in the same cycle, `err_cnt` increments by 2.

## Timing

- All outputs except `term_rd` come from flops.
- Forward latency is 1 cycle: a word accepted in cycle N appears with `usr_wr`=1 in cycle N+1.
- `usr_wr` is high for exactly one cycle per forwarded word. Forwarded words keep their order and sot/eot flags.
- `len_err` and `proto_err` are registered. They pulse in the cycle after the triggering word is accepted.
- Counters update in the same cycle as their error or eot pulse.
- Full throughput is 1 word per cycle while `term_empty`=0 and `usr_afull`=0.
- `usr_afull` asserting in cycle N blocks acceptance in cycle N. The word already registered from cycle N-1 still writes; the 2-entry margin covers it.
- DROP never stalls on `usr_afull`.
- Reset values: state IDLE, word counter 0, all counters 0. `usr_wr`, `usr_sot`, `usr_eot`, `len_err` and `proto_err` are 0, and `usr_data` is 0.
- Reset mid-TLV abandons the TLV. No eot is emitted after reset.

## Test plan

- Directed TLVs are applied to the terminate interface. The required response on the user FIFO and the status outputs is listed for each.
- 3-word TLV, type 0x05, length 3, `drop_en`=0, `usr_afull`=0:
  - Response: 3 `usr_wr` pulses in consecutive cycles, the first one cycle after the first `term_rd`, with sot on word 1 and eot on word 3.
  - `tlv_pass_cnt`=1. No error pulses.
- `drop_en`=1, `drop_type`=0x05; send a type-0x05 TLV (4 words), then a type-0x06 TLV (2 words):
  - Response: only the 2 type-0x06 words appear on the user FIFO.
  - `tlv_drop_cnt`=1, `tlv_pass_cnt`=1.
  - `term_rd` stays high for all 6 words even with `usr_afull`=1 during the drop.
- Length mismatch: header length 4, eot on word 2:
  - Response: 2 words forwarded, `len_err` pulses once, `err_cnt`=1.
  - Also a single-word TLV with length 0: `len_err` pulses.
- Missing eot: sot(len 3), mid word, then sot(len 1, eot):
  - Response: `proto_err` pulses once.
  - 3 words forwarded with only the final word carrying eot; `tlv_pass_cnt`=1, `err_cnt`=1.
  - Orphan word with sot=0 in IDLE: discarded, `proto_err` pulses, `err_cnt`=2.
- Backpressure: random `usr_afull` toggling over 1000 words:
  - Response: zero writes in any cycle more than 1 cycle after `usr_afull` rose.
  - Output stream equals input stream; no loss, no duplication.
- Reset asserted in the middle of a 5-word TLV:
  - Response: outputs and counters go to 0 immediately.
  - After release, a new TLV is forwarded normally with `proto_err`=0.
